sata_txalign_sched: RTL and testbench
=====================================

// Module: sata_txalign_sched
// PURPOSE
//  Schedules the TX dword stream into the PHY reset/link sequencer once the link is up.
//  Arbitrates each TX slot between the link layer and mandatory ALIGN insertion:
//  ALIGN_COUNT ALIGNs open every ALIGN_INTERVAL-dword period. Idle slots are filled with SYNC.
//  Sits between the link layer and sata_reset's i_tx_primitive/i_tx_data/o_tx_ready ports.
// PARAMETERS
//  ALIGN_INTERVAL  256  dwords per period, ALIGN slots included; legal range 4..4096
//  ALIGN_COUNT     2    consecutive ALIGN dwords at the start of each period; 1..ALIGN_INTERVAL-2
// PORTS
//  i_tx_clk       in   1   TX word clock; the only clock
//  i_reset        in   1   reset, asynchronous, active-low
//  i_link_up      in   1   link-up status from the reset sequencer
//  i_tx_ready     in   1   sequencer consumes o_tx_* on every clock this is high
//  i_valid        in   1   link layer has a dword to send
//  o_ready        out  1   link-layer dword is accepted this cycle (i_valid && o_ready)
//  i_primitive    in   1   link-layer dword is a primitive
//  i_data         in   32  link-layer dword
//  o_tx_primitive out  1   registered TX primitive flag to the sequencer
//  o_tx_data      out  32  registered TX dword to the sequencer
//  o_in_align     out  1   high while the next dword loaded is an ALIGN slot
// BEHAVIOUR
//  Reset (i_reset low, async): state=IDLE, slot=0, {o_tx_primitive,o_tx_data}=P_ALIGN, o_in_align=0.
//  o_ready is combinational: o_ready = i_link_up && i_tx_ready && (state==DATA).
//  advance = i_link_up && i_tx_ready. Registers update only on advance.
//  When !i_link_up, registers are forced to IDLE state as described below.
//  Output register load on advance:
//   - ALIGN state: load P_ALIGN.
//   - DATA state with i_valid: load {i_primitive,i_data}.
//   - DATA state without i_valid: load P_SYNC. This fill is not a handshake.
//  Latency: a dword accepted on clock N appears on o_tx_* after edge N, one cycle.
//  slot counter: width $clog2(ALIGN_INTERVAL).
//   - Increments on every advance.
//   - Wraps from ALIGN_INTERVAL-1 to 0.
//   - Counts dwords, not cycles.
//  FSM states and transitions:
//   - IDLE: output held at P_ALIGN, slot=0.
//     * i_link_up -> ALIGN. No dword is loaded on this edge.
//   - ALIGN: each advance loads one ALIGN.
//     * After the ALIGN_COUNT-th ALIGN load (slot==ALIGN_COUNT-1) -> DATA.
//   - DATA: each advance loads a data/SYNC dword.
//     * On the load at slot==ALIGN_INTERVAL-1 -> ALIGN (slot wraps to 0).
//   - Any state with !i_link_up, checked first -> IDLE.
//     * Output reloads P_ALIGN, slot=0, o_ready low in the same cycle.
//     * A word presented with i_valid while the link drops is NOT consumed.
//  o_in_align = (state==ALIGN). The link layer holds i_valid/i_data stable while o_ready is low.
//  i_tx_ready low while link up: outputs, state and slot all hold.
//   - ALIGN spacing is preserved in dwords, not in cycles.
//  Every relink starts a fresh period with ALIGN_COUNT ALIGNs before any data.
//  An upstream P_ALIGN in a DATA slot passes through as data and does not reset slot.
//  P_ALIGN and P_SYNC come from sata_primitives.vh. Data dwords are never modified.
// TESTING
//  1. Link up, i_tx_ready=1, i_valid=1 with data 0,1,2,...
//     -> o_tx: ALIGN,ALIGN,0..253,ALIGN,ALIGN,254,...
//     -> o_ready low exactly 2 of every 256 cycles.
//  2. Link up, i_valid=0 throughout
//     -> o_tx: ALIGN,ALIGN, then 254xP_SYNC, repeating.
//     -> o_ready high in DATA slots, but no word consumed.
//  3. Toggle i_tx_ready 1/0 every cycle with data streaming
//     -> o_tx holds on stalled cycles.
//     -> ALIGN pair still after every 254 accepted words; no word lost or duplicated.
//  4. Drop i_link_up at data slot 100 with i_valid=1, word 0xA5A5A5A5
//     -> o_ready=0 that cycle; next o_tx=P_ALIGN.
//     -> On relink, ALIGN,ALIGN,then 0xA5A5A5A5.
//  5. Assert i_reset mid-ALIGN pair
//     -> o_tx=P_ALIGN immediately, asynchronously.
//     -> o_in_align=0; after release and link up, a full ALIGN pair precedes data.
//  6. ALIGN_INTERVAL=8, ALIGN_COUNT=1, continuous data
//     -> ALIGN,d0..d6,ALIGN,d7..d13; slot wraps cleanly at 7->0.

Source files
------------

// File: rtl/sata_txalign_sched.sv
// sata_txalign_sched: arbitrates TX dword slots between link-layer data, periodic ALIGN insertion and SYNC fill
module sata_txalign_sched #(
  parameter int          ALIGN_INTERVAL = 256,
  parameter int          ALIGN_COUNT    = 2,
  parameter logic [31:0] P_ALIGN        = 32'h7B4A4ABC,
  parameter logic [31:0] P_SYNC         = 32'hB5B5957C
) (
  input  logic        i_tx_clk,
  input  logic        i_reset,
  input  logic        i_link_up,
  input  logic        i_tx_ready,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_primitive,
  input  logic [31:0] i_data,
  output logic        o_tx_primitive,
  output logic [31:0] o_tx_data,
  output logic        o_in_align
);
  localparam int SW = $clog2(ALIGN_INTERVAL);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(ALIGN_INTERVAL - 1);
  localparam logic [SW-1:0] ALIGN_LAST = SW'(ALIGN_COUNT - 1);
  typedef enum logic [1:0] {IDLE, ALIGN, DATA} state_t;
  state_t        state, state_n;
  logic [SW-1:0] slot, slot_n;
  logic          prim_n;
  logic [31:0]   data_n;
  assign o_ready    = i_link_up && i_tx_ready && (state == DATA);
  assign o_in_align = (state == ALIGN);
  // next state, slot and output word; link loss wins over everything, a stalled sequencer freezes all
  always_comb begin
    state_n = state;
    slot_n  = slot;
    prim_n  = o_tx_primitive;
    data_n  = o_tx_data;
    if (!i_link_up) begin
      state_n = IDLE;
      slot_n  = '0;
      prim_n  = 1'b1;
      data_n  = P_ALIGN;
    end else if (i_tx_ready) begin
      if (state == IDLE) begin
        state_n = ALIGN;
      end else begin
        slot_n = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        if (state == ALIGN) begin
          prim_n  = 1'b1;
          data_n  = P_ALIGN;
          state_n = (slot == ALIGN_LAST) ? DATA : ALIGN;
        end else begin
          prim_n  = i_valid ? i_primitive : 1'b1;
          data_n  = i_valid ? i_data : P_SYNC;
          state_n = (slot == SLOT_LAST) ? ALIGN : DATA;
        end
      end
    end
  end
  // state, slot counter and registered TX word
  always_ff @(posedge i_tx_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      slot           <= '0;
      o_tx_primitive <= 1'b1;
      o_tx_data      <= P_ALIGN;
    end else begin
      state          <= state_n;
      slot           <= slot_n;
      o_tx_primitive <= prim_n;
      o_tx_data      <= data_n;
    end
  end
endmodule

// File: tb/tb_sata_txalign_sched.sv
// tb_sata_txalign_sched: dword-level model check of two scheduler configurations plus literal pins
module tb_sata_txalign_sched;
  localparam logic [32:0] ALIGN33 = {1'b1, 32'h7B4A4ABC};
  localparam logic [32:0] SYNC33  = {1'b1, 32'hB5B5957C};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link = 1'b0;
  logic rdy = 1'b1;
  logic valid = 1'b0;
  logic        prim_in[2];
  logic [31:0] data_in[2];
  logic        o_prim[2];
  logic [31:0] o_data[2];
  logic        o_inal[2];
  logic        o_rdy[2];
  int ai[2] = '{256, 8};
  int ac[2] = '{2, 1};
  int passed = 0;
  int total = 0;
  logic        m_up[2];
  int          m_k[2];
  logic [32:0] m_out[2];
  logic [31:0] src[2];
  logic [32:0] log0[1:300];
  logic [32:0] log1[1:300];
  always #5 clk = ~clk;
  sata_txalign_sched #(.ALIGN_INTERVAL(256), .ALIGN_COUNT(2)) u0 (
    .i_tx_clk(clk), .i_reset(rst_n), .i_link_up(link), .i_tx_ready(rdy),
    .i_valid(valid), .o_ready(o_rdy[0]), .i_primitive(prim_in[0]), .i_data(data_in[0]),
    .o_tx_primitive(o_prim[0]), .o_tx_data(o_data[0]), .o_in_align(o_inal[0])
  );
  sata_txalign_sched #(.ALIGN_INTERVAL(8), .ALIGN_COUNT(1)) u1 (
    .i_tx_clk(clk), .i_reset(rst_n), .i_link_up(link), .i_tx_ready(rdy),
    .i_valid(valid), .o_ready(o_rdy[1]), .i_primitive(prim_in[1]), .i_data(data_in[1]),
    .o_tx_primitive(o_prim[1]), .o_tx_data(o_data[1]), .o_in_align(o_inal[1])
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
  endtask
  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      data_in[d] = src[d];
      prim_in[d] = (src[d][3:0] == 4'hF);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask
  // dword-level model: after link-up one idle edge, then every advance is dword k of a period of ai,
  // the first ac of which are ALIGN; the source word only moves on when a handshake is predicted
  initial begin
    logic al, er;
    for (int d = 0; d < 2; d++) begin
      m_up[d] = 1'b0; m_k[d] = 0; m_out[d] = ALIGN33; src[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          m_up[d] = 1'b0; m_k[d] = 0; m_out[d] = ALIGN33;
        end
        al = m_up[d] && ((m_k[d] % ai[d]) < ac[d]);
        er = rst_n && link && rdy && m_up[d] && !al;
        chk($sformatf("tx%0d", d), {31'b0, o_prim[d], o_data[d]}, {31'b0, m_out[d]});
        chk($sformatf("in_align%0d", d), o_inal[d], al);
        chk($sformatf("ready%0d", d), o_rdy[d], er);
        if (rst_n) begin
          if (!link) begin
            m_up[d] = 1'b0; m_k[d] = 0; m_out[d] = ALIGN33;
          end else if (rdy) begin
            if (!m_up[d]) m_up[d] = 1'b1;
            else begin
              m_out[d] = al ? ALIGN33 : valid ? {prim_in[d], data_in[d]} : SYNC33;
              m_k[d]++;
            end
          end
          if (er && valid) src[d]++;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int lowcnt, n, c0, c1;
    logic [31:0] s0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {o_prim[0], o_data[0]}, ALIGN33);
    chk("reset_in_align", o_inal[0], 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    valid = 1'b1;
    link = 1'b1;
    lowcnt = 0;
    for (int p = 1; p <= 270; p++) begin
      tick();
      log0[p] = {o_prim[0], o_data[0]};
      log1[p] = {o_prim[1], o_data[1]};
      if (p >= 3 && p <= 258 && !o_rdy[0]) lowcnt++;
    end
    chk("s1_first_align_a", log0[2], ALIGN33);
    chk("s1_first_align_b", log0[3], ALIGN33);
    chk("s1_d0", log0[4], 33'h0_0000_0000);
    chk("s1_d253", log0[257], 33'h0_0000_00FD);
    chk("s1_wrap_align_a", log0[258], ALIGN33);
    chk("s1_wrap_align_b", log0[259], ALIGN33);
    chk("s1_d254", log0[260], 33'h0_0000_00FE);
    chk("s1_prim_pass", log0[261], 33'h1_0000_00FF);
    chk("s1_ready_low_per_period", lowcnt, 2);
    chk("s6_align", log1[2], ALIGN33);
    chk("s6_d0", log1[3], 33'h0_0000_0000);
    chk("s6_d6", log1[9], 33'h0_0000_0006);
    chk("s6_wrap_align", log1[10], ALIGN33);
    chk("s6_d7", log1[11], 33'h0_0000_0007);
    chk("s6_d15_prim", log1[20], 33'h1_0000_000F);
    for (int i = 0; i < 600; i++) begin
      rdy = (i % 2 == 0);
      tick();
    end
    rdy = 1'b1;
    n = 0;
    while (!(m_up[0] && (m_k[0] % 256) == 100) && n < 600) begin
      tick();
      n++;
    end
    chk("s4_reach_slot100", n < 600, 1'b1);
    src[0] = 32'hA5A5A5A5;
    link = 1'b0;
    drive();
    #1;
    chk("s4_drop_ready", o_rdy[0], 1'b0);
    tick();
    chk("s4_drop_tx", {o_prim[0], o_data[0]}, ALIGN33);
    chk("s4_drop_in_align", o_inal[0], 1'b0);
    link = 1'b1;
    tick();
    chk("s4_relink_in_align", o_inal[0], 1'b1);
    tick();
    chk("s4_relink_align_a", {o_prim[0], o_data[0]}, ALIGN33);
    tick();
    chk("s4_relink_align_b", {o_prim[0], o_data[0]}, ALIGN33);
    chk("s4_relink_ready", o_rdy[0], 1'b1);
    tick();
    chk("s4_held_word", {o_prim[0], o_data[0]}, 33'h0_A5A5_A5A5);
    valid = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if ({o_prim[0], o_data[0]} == SYNC33) c0++;
      if ({o_prim[1], o_data[1]} == SYNC33) c1++;
    end
    chk("s2_sync_count0", c0, 254);
    chk("s2_sync_count1", c1, 224);
    valid = 1'b1;
    link = 1'b0;
    tick();
    link = 1'b1;
    tick();
    tick();
    chk("s5_pre_in_align", o_inal[0], 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_async_tx", {o_prim[0], o_data[0]}, ALIGN33);
    chk("s5_async_in_align", o_inal[0], 1'b0);
    chk("s5_async_ready", o_rdy[0], 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("s5_rel_in_align", o_inal[0], 1'b1);
    tick();
    chk("s5_rel_align_a", {o_prim[0], o_data[0]}, ALIGN33);
    tick();
    chk("s5_rel_align_b", {o_prim[0], o_data[0]}, ALIGN33);
    s0 = src[0];
    tick();
    chk("s5_rel_data", {o_prim[0], o_data[0]}, {s0[3:0] == 4'hF, s0});
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_data_async_tx", {o_prim[0], o_data[0]}, ALIGN33);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
